// File: rtl/tachometer_multi.sv
// Multi-channel encoder tachometer: synchronised edge counting per channel over a fixed gate
// window, with latched per-window counts, a sample pulse and sticky saturation flags.
module tachometer_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 32,
    parameter int CLOCK_FREQ   = 100000000,
    parameter int GATE_HZ      = 1000,
    parameter int SYNC_STAGES  = 2,
    parameter int EDGE_MODE    = 0
) (
    input  logic                                clock,
    input  logic                                system_reset,
    input  logic                                enable,
    input  logic [NUM_CHANNELS-1:0]             encoder_in,
    input  logic [NUM_CHANNELS-1:0]             clear_overflow,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] data_out,
    output logic                                sample_valid,
    output logic [NUM_CHANNELS-1:0]             overflow
);

    localparam int NUM_CLOCKS = CLOCK_FREQ / GATE_HZ;
    localparam int GATE_WIDTH = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
    localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(NUM_CLOCKS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [SYNC_STAGES-1:0][NUM_CHANNELS-1:0] sync_q;
    logic [NUM_CHANNELS-1:0]                  sync;
    logic [NUM_CHANNELS-1:0]                  hist;
    logic [NUM_CHANNELS-1:0]                  pulse;
    logic [GATE_WIDTH-1:0]                    gate_count;
    logic                                     terminal;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] pulse_count;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] count_next;
    logic [NUM_CHANNELS-1:0]                  sat_hit;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign pulse    = (EDGE_MODE == 1) ? (sync ^ hist) : (sync & ~hist);
    assign terminal = enable && (gate_count == GATE_LAST);

    // Saturating increment shared by the running count and the window-close latch.
    always_comb begin
        count_next = pulse_count;
        sat_hit    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (pulse[i]) begin
                if (pulse_count[i] == COUNT_MAX) begin
                    sat_hit[i] = 1'b1;
                end else begin
                    count_next[i] = pulse_count[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // NOTE: every register, including the sync chain, is cleared by reset so the first
    // window after release starts from a known state; all state updates use <= only.
    always_ff @(posedge clock) begin
        if (system_reset) begin
            sync_q       <= '0;
            hist         <= '0;
            gate_count   <= '0;
            pulse_count  <= '0;
            data_out     <= '0;
            sample_valid <= 1'b0;
            overflow     <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], encoder_in};
            hist         <= sync;
            sample_valid <= terminal;
            // A saturating edge in the same cycle as a clear keeps the flag set.
            overflow     <= (overflow & ~clear_overflow) | (enable ? sat_hit : '0);
            if (!enable) begin
                gate_count  <= '0;
                pulse_count <= '0;
            end else if (terminal) begin
                gate_count  <= '0;
                data_out    <= count_next;
                pulse_count <= '0;
            end else begin
                gate_count  <= gate_count + GATE_WIDTH'(1);
                pulse_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_tachometer_multi.sv
// Directed bench for tachometer_multi: three instances (32-bit rising, 3-bit rising, 32-bit both edges)
// sharing clock, reset and enable, with windows of 100 cycles.
module tb_tachometer_multi;

    logic        clock = 1'b0;
    logic        system_reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  enc_a = '0;
    logic [3:0]  enc_b = '0;
    logic [3:0]  clear_b = '0;
    logic [3:0]  clear_none = '0;
    logic [127:0] data_a, data_c;
    logic [11:0] data_b;
    logic        valid_a, valid_b, valid_c;
    logic [3:0]  ovf_a, ovf_b, ovf_c;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  gen_a = 1'b0;
    bit  gen_b = 1'b0;
    int  n;
    int  pulses;

    always #5 clock = ~clock;

    tachometer_multi #(.NUM_CHANNELS(4), .COUNT_WIDTH(32), .CLOCK_FREQ(1000), .GATE_HZ(10),
                       .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
        .clock(clock), .system_reset(system_reset), .enable(enable), .encoder_in(enc_a),
        .clear_overflow(clear_none), .data_out(data_a), .sample_valid(valid_a), .overflow(ovf_a));

    tachometer_multi #(.NUM_CHANNELS(4), .COUNT_WIDTH(3), .CLOCK_FREQ(1000), .GATE_HZ(10),
                       .SYNC_STAGES(2), .EDGE_MODE(0)) dut_b (
        .clock(clock), .system_reset(system_reset), .enable(enable), .encoder_in(enc_b),
        .clear_overflow(clear_b), .data_out(data_b), .sample_valid(valid_b), .overflow(ovf_b));

    tachometer_multi #(.NUM_CHANNELS(4), .COUNT_WIDTH(32), .CLOCK_FREQ(1000), .GATE_HZ(10),
                       .SYNC_STAGES(2), .EDGE_MODE(1)) dut_c (
        .clock(clock), .system_reset(system_reset), .enable(enable), .encoder_in(enc_a),
        .clear_overflow(clear_none), .data_out(data_c), .sample_valid(valid_c), .overflow(ovf_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and update the square-wave generators.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (gen_a) begin
            enc_a[0] = (cyc % 10) < 5;
            enc_a[1] = (cyc % 20) < 10;
            enc_a[2] = (cyc % 50) < 25;
            enc_a[3] = (cyc % 100) < 50;
        end
        if (gen_b) enc_b[0] = (cyc % 4) < 2;
    endtask

    task automatic ticks(input int count);
        for (int i = 0; i < count; i++) tick();
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!valid_a && waited < 300);
        if (!valid_a) check("valid_timeout", 64'(valid_a), 64'd1);
    endtask

    task automatic check_rates(input string tag);
        check({tag, "_ch0"}, 64'(data_a[31:0]), 64'd10);
        check({tag, "_ch1"}, 64'(data_a[63:32]), 64'd5);
        check({tag, "_ch2"}, 64'(data_a[95:64]), 64'd2);
        check({tag, "_ch3"}, 64'(data_a[127:96]), 64'd1);
        check({tag, "_both_ch1"}, 64'(data_c[63:32]), 64'd10);
        check({tag, "_ovf_a"}, 64'(ovf_a), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_a"}, 64'(data_a != '0), 64'd0);
        check({tag, "_data_b"}, 64'(data_b), 64'd0);
        check({tag, "_data_c"}, 64'(data_c != '0), 64'd0);
        check({tag, "_valid"}, 64'({valid_a, valid_b, valid_c}), 64'd0);
        check({tag, "_ovf"}, 64'({ovf_a, ovf_b, ovf_c}), 64'd0);
    endtask

    initial begin
        // Reset with encoders toggling.
        gen_a = 1'b1;
        gen_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid_a || valid_b || valid_c) pulses++;
        end
        check("reset_no_valid", 64'(pulses), 64'd0);
        check_all_zero("reset");
        system_reset = 1'b0;
        ticks(10);

        // Rates: enable rises in this cycle, window closes NUM_CLOCKS cycles on.
        enable = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_valid(n);
            check("rate_interval", 64'(n), (w == 0) ? 64'd100 : 64'd99);
            check_rates("rate");
            check("sat_data_b", 64'(data_b[2:0]), 64'd7);
            check("sat_ovf_b", 64'(ovf_b), 64'd1);
            tick();
            check("valid_one_cycle", 64'(valid_a), 64'd0);
        end

        // Enable dropped at gate count 50 for 30 cycles.
        ticks(49);
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_a) pulses++;
        end
        check("enable_off_no_valid", 64'(pulses), 64'd0);
        check("enable_off_hold_ch0", 64'(data_a[31:0]), 64'd10);
        check("enable_off_hold_ovf_b", 64'(ovf_b), 64'd1);
        enable = 1'b1;
        wait_valid(n);
        check("reenable_latency", 64'(n), 64'd100);
        check_rates("reenable");

        // Boundary: edges landing on the terminal cycle and one cycle after it.
        gen_a = 1'b0;
        enc_a = '0;
        wait_valid(n);
        wait_valid(n);
        check("quiet_ch0", 64'(data_a[31:0]), 64'd0);
        ticks(97);
        enc_a[0] = 1'b1;
        wait_valid(n);
        check("boundary_terminal", 64'(data_a[31:0]), 64'd1);
        enc_a[0] = 1'b0;
        ticks(98);
        enc_a[0] = 1'b1;
        wait_valid(n);
        check("boundary_late_closing", 64'(data_a[31:0]), 64'd0);
        wait_valid(n);
        check("boundary_late_next", 64'(data_a[31:0]), 64'd1);

        // Overflow clear in an edge-free window, then clear racing a saturating edge.
        gen_b = 1'b0;
        enc_b = '0;
        wait_valid(n);
        wait_valid(n);
        check("quiet_data_b", 64'(data_b[2:0]), 64'd0);
        check("quiet_ovf_b_sticky", 64'(ovf_b), 64'd1);
        ticks(10);
        clear_b[0] = 1'b1;
        tick();
        clear_b[0] = 1'b0;
        check("ovf_cleared", 64'(ovf_b), 64'd0);
        gen_b = 1'b1;
        wait_valid(n);
        ticks(40);
        while ((cyc % 4) != 2) tick();
        check("ovf_reset_before_race", 64'(ovf_b), 64'd1);
        clear_b[0] = 1'b1;
        tick();
        clear_b[0] = 1'b0;
        check("ovf_set_wins", 64'(ovf_b), 64'd1);

        // Mid-window reset, then a clean restart.
        gen_a = 1'b1;
        wait_valid(n);
        wait_valid(n);
        ticks(30);
        system_reset = 1'b1;
        ticks(2);
        check_all_zero("midreset");
        system_reset = 1'b0;
        enable = 1'b0;
        ticks(10);
        enable = 1'b1;
        wait_valid(n);
        check("restart_latency", 64'(n), 64'd100);
        check_rates("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
